// File: rtl/avalon_wait_ram_if.sv
// avalon_wait_ram_if: Avalon-MM word bus between the CPU master and the bench RAM
interface avalon_wait_ram_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  modport master (output address, read, write, writedata, byteenable, input waitrequest, readdata);
  modport slave (input address, read, write, writedata, byteenable, output waitrequest, readdata);
endinterface

// File: rtl/avalon_wait_ram.sv
// avalon_wait_ram: Avalon-MM slave word RAM with fixed or LFSR-jittered wait states, preload and sticky error flags
module avalon_wait_ram #(
  parameter int          MEM_WORDS   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1,
  parameter int          STALL_MODE  = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  localparam int         IDX_W       = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  avalon_wait_ram_if.slave bus,
  input  logic             preload_en,
  input  logic [IDX_W-1:0] preload_addr,
  input  logic [31:0]      preload_data,
  output logic             proto_err,
  output logic             misalign_err,
  output logic [15:0]      xfer_count
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [7:0] SEED = LFSR_SEED == 8'h00 ? 8'h01 : LFSR_SEED;
  state_t           state, state_n;
  logic [4:0]       cnt, cnt_n, tgt, tgt_n, lat;
  logic [7:0]       lfsr;
  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic             req, both, acc;
  assign idx  = IDX_W'((bus.address - BASE_ADDR) >> 2);
  assign req  = bus.read ^ bus.write;
  assign both = bus.read & bus.write;
  // state register: transfer phase, elapsed wait count and latched target latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      tgt   <= 5'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tgt   <= tgt_n;
    end
  end
  // next state: latency sampled on first sight of a request, accept once the count reaches it
  always_comb begin
    lat     = 5'(WAIT_CYCLES) + (STALL_MODE != 0 ? {3'b000, lfsr[1:0]} : 5'd0);
    acc     = !reset && req && (state == IDLE ? lat == 5'd0 : cnt == tgt);
    state_n = (state == IDLE && req && lat != 5'd0) ? BUSY :
              (state == BUSY && (!req || cnt == tgt)) ? IDLE : state;
    cnt_n   = state == IDLE ? 5'd1 : cnt + 5'd1;
    tgt_n   = state == IDLE ? lat : tgt;
  end
  // outputs: stall while reset or waiting, read data only in the accept cycle
  always_comb begin
    bus.waitrequest = reset || (state == IDLE ? req && lat != 5'd0 : cnt < tgt);
    bus.readdata    = acc && bus.read ? mem[idx] : 32'h0;
  end
  // status: sticky errors, transfer counter and jitter LFSR stepped once per accepted transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err    <= 1'b0;
      misalign_err <= 1'b0;
      xfer_count   <= 16'h0;
      lfsr         <= SEED;
    end else begin
      if (both || (state == BUSY && !req)) proto_err <= 1'b1;
      if (acc && bus.address[1:0] != 2'b00) misalign_err <= 1'b1;
      if (acc) begin
        xfer_count <= xfer_count + 16'h1;
        lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
    end
  end
  // memory: preload always commits and overrides a bus write to the same word
  always_ff @(posedge clk) begin
    if (preload_en) mem[preload_addr] <= preload_data;
    if (acc && bus.write && !(preload_en && preload_addr == idx))
      for (int b = 0; b < 4; b++)
        if (bus.byteenable[b]) mem[idx][8*b +: 8] <= bus.writedata[8*b +: 8];
  end
endmodule

// File: tb/tb_avalon_wait_ram.sv
// tb_avalon_wait_ram: directed vector table plus multi-cycle stall, error and reset sequences
module tb_avalon_wait_ram;
  logic        clk, reset;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  logic        pe0, me0, pe3, me3, pes, mes;
  logic [15:0] xc0, xc3, xcs;
  int          pass, total;
  avalon_wait_ram_if bus0 ();
  avalon_wait_ram_if bus3 ();
  avalon_wait_ram_if buss ();
  avalon_wait_ram #(.WAIT_CYCLES(0)) d0 (
    .clk(clk), .reset(reset), .bus(bus0), .preload_en(pl_en), .preload_addr(pl_addr),
    .preload_data(pl_data), .proto_err(pe0), .misalign_err(me0), .xfer_count(xc0));
  avalon_wait_ram #(.WAIT_CYCLES(3)) d3 (
    .clk(clk), .reset(reset), .bus(bus3), .preload_en(pl_en), .preload_addr(pl_addr),
    .preload_data(pl_data), .proto_err(pe3), .misalign_err(me3), .xfer_count(xc3));
  avalon_wait_ram #(.WAIT_CYCLES(1), .STALL_MODE(1)) ds (
    .clk(clk), .reset(reset), .bus(buss), .preload_en(pl_en), .preload_addr(pl_addr),
    .preload_data(pl_data), .proto_err(pes), .misalign_err(mes), .xfer_count(xcs));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic        pl;
    logic [7:0]  pa;
    logic [31:0] pd;
    logic        rd, wr;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        ew;
    logic [31:0] er;
    logic [15:0] ec;
    logic        ep, em;
  } vec_t;
  vec_t v[18];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s got=%h expected=%h", nm, got, exp);
  endtask
  task automatic xwait(input int sel, output int n, output logic [31:0] d);
    logic        w;
    logic [31:0] r;
    n = 0;
    d = 32'hDEAD_DEAD;
    repeat (40) begin
      #1;
      w = sel == 1 ? bus3.waitrequest : buss.waitrequest;
      r = sel == 1 ? bus3.readdata : buss.readdata;
      if (!w) begin
        d = r;
        @(negedge clk);
        return;
      end
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    int          n, seq[50];
    logic [31:0] d;
    logic        varied;
    pass = 0; total = 0;
    v[0]  = '{1'b1, 8'd0, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0,   32'h0,        4'h0, 1'b0, 32'h0,        16'd0,  1'b0, 1'b0};
    v[1]  = '{1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 32'd4,   32'h0,        4'h0, 1'b0, 32'h24020010, 16'd0,  1'b0, 1'b0};
    v[2]  = '{1'b0, 8'd0, 32'h0,        1'b0, 1'b0, 32'd0,   32'h0,        4'h0, 1'b0, 32'h0,        16'd1,  1'b0, 1'b0};
    v[3]  = '{1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 32'd8,   32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        16'd1,  1'b0, 1'b0};
    v[4]  = '{1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 32'd8,   32'h00000000, 4'h5, 1'b0, 32'h0,        16'd2,  1'b0, 1'b0};
    v[5]  = '{1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 32'd8,   32'h0,        4'h0, 1'b0, 32'hFF00FF00, 16'd3,  1'b0, 1'b0};
    v[6]  = '{1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 32'd8,   32'h00000000, 4'h0, 1'b0, 32'h0,        16'd4,  1'b0, 1'b0};
    v[7]  = '{1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 32'd8,   32'h0,        4'h0, 1'b0, 32'hFF00FF00, 16'd5,  1'b0, 1'b0};
    v[8]  = '{1'b1, 8'd3, 32'hAABBCCDD, 1'b0, 1'b1, 32'd12,  32'h12345678, 4'hF, 1'b0, 32'h0,        16'd6,  1'b0, 1'b0};
    v[9]  = '{1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 32'd12,  32'h0,        4'h0, 1'b0, 32'hAABBCCDD, 16'd7,  1'b0, 1'b0};
    v[10] = '{1'b1, 8'd5, 32'h55555555, 1'b0, 1'b1, 32'd16,  32'h11111111, 4'hF, 1'b0, 32'h0,        16'd8,  1'b0, 1'b0};
    v[11] = '{1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 32'd16,  32'h0,        4'h0, 1'b0, 32'h11111111, 16'd9,  1'b0, 1'b0};
    v[12] = '{1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 32'd20,  32'h0,        4'h0, 1'b0, 32'h55555555, 16'd10, 1'b0, 1'b0};
    v[13] = '{1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 32'h402, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D, 16'd11, 1'b0, 1'b0};
    v[14] = '{1'b0, 8'd0, 32'h0,        1'b0, 1'b0, 32'd0,   32'h0,        4'h0, 1'b0, 32'h0,        16'd12, 1'b0, 1'b1};
    v[15] = '{1'b0, 8'd0, 32'h0,        1'b1, 1'b1, 32'd8,   32'h00000000, 4'hF, 1'b0, 32'h0,        16'd12, 1'b0, 1'b1};
    v[16] = '{1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 32'd8,   32'h0,        4'h0, 1'b0, 32'hFF00FF00, 16'd12, 1'b1, 1'b1};
    v[17] = '{1'b0, 8'd0, 32'h0,        1'b0, 1'b0, 32'd0,   32'h0,        4'h0, 1'b0, 32'h0,        16'd13, 1'b1, 1'b1};
    {bus0.read, bus0.write, bus0.address, bus0.writedata, bus0.byteenable} = '0;
    {bus3.read, bus3.write, bus3.address, bus3.writedata, bus3.byteenable} = '0;
    {buss.read, buss.write, buss.address, buss.writedata, buss.byteenable} = '0;
    reset = 1'b1; pl_en = 1'b1; pl_addr = 8'd1; pl_data = 32'h24020010;
    bus0.read = 1'b1; bus0.address = 32'd4;
    @(negedge clk); #1;
    chk("reset_wait", 32'(bus0.waitrequest), 32'd1);
    chk("reset_rdata", bus0.readdata, 32'h0);
    chk("reset_count", 32'(xc0), 32'd0);
    chk("reset_flags", {30'd0, pe0, me0}, 32'd0);
    @(negedge clk);
    reset = 1'b0; pl_en = 1'b0; bus0.read = 1'b0;
    for (int i = 0; i < 18; i++) begin
      pl_en = v[i].pl; pl_addr = v[i].pa; pl_data = v[i].pd;
      bus0.read = v[i].rd; bus0.write = v[i].wr; bus0.address = v[i].a;
      bus0.writedata = v[i].wd; bus0.byteenable = v[i].be;
      #1;
      chk($sformatf("vec%0d_wait", i), 32'(bus0.waitrequest), 32'(v[i].ew));
      chk($sformatf("vec%0d_rdata", i), bus0.readdata, v[i].er);
      chk($sformatf("vec%0d_count", i), 32'(xc0), 32'(v[i].ec));
      chk($sformatf("vec%0d_proto", i), 32'(pe0), 32'(v[i].ep));
      chk($sformatf("vec%0d_misalign", i), 32'(me0), 32'(v[i].em));
      @(negedge clk);
    end
    {bus0.read, bus0.write} = 2'b00;
    pl_en = 1'b1; pl_addr = 8'd7; pl_data = 32'h0BADBEEF;
    @(negedge clk);
    pl_addr = 8'd9; pl_data = 32'h13579BDF;
    @(negedge clk);
    pl_en = 1'b0;
    bus3.read = 1'b1; bus3.address = 32'd28;
    xwait(1, n, d);
    chk("w3_first_stall", n, 32'd3);
    chk("w3_first_data", d, 32'h0BADBEEF);
    chk("w3_first_count", 32'(xc3), 32'd1);
    xwait(1, n, d);
    chk("w3_b2b_stall", n, 32'd3);
    chk("w3_b2b_data", d, 32'h0BADBEEF);
    chk("w3_b2b_count", 32'(xc3), 32'd2);
    bus3.read = 1'b0; bus3.write = 1'b1; bus3.writedata = 32'h0; bus3.byteenable = 4'b0011;
    xwait(1, n, d);
    chk("w3_write_stall", n, 32'd3);
    bus3.write = 1'b0; bus3.read = 1'b1;
    xwait(1, n, d);
    chk("w3_rmw_data", d, 32'h0BAD0000);
    chk("w3_rmw_count", 32'(xc3), 32'd4);
    bus3.read = 1'b0;
    @(negedge clk);
    bus3.read = 1'b1;
    #1 chk("drop_stall0", 32'(bus3.waitrequest), 32'd1);
    @(negedge clk);
    #1 chk("drop_stall1", 32'(bus3.waitrequest), 32'd1);
    chk("drop_proto_before", 32'(pe3), 32'd0);
    @(negedge clk);
    bus3.read = 1'b0;
    @(negedge clk);
    #1 chk("drop_proto_after", 32'(pe3), 32'd1);
    chk("drop_count", 32'(xc3), 32'd4);
    bus3.read = 1'b1;
    xwait(1, n, d);
    chk("drop_fresh_stall", n, 32'd3);
    chk("drop_fresh_data", d, 32'h0BAD0000);
    chk("drop_fresh_count", 32'(xc3), 32'd5);
    bus3.read = 1'b0; bus3.write = 1'b1; bus3.address = 32'd36;
    bus3.writedata = 32'h0; bus3.byteenable = 4'hF;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("abort_wait", 32'(bus3.waitrequest), 32'd1);
    @(negedge clk);
    reset = 1'b0; bus3.write = 1'b0;
    #1 chk("abort_count", 32'(xc3), 32'd0);
    chk("abort_proto", 32'(pe3), 32'd0);
    @(negedge clk);
    bus3.read = 1'b1;
    xwait(1, n, d);
    chk("abort_stall", n, 32'd3);
    chk("abort_data", d, 32'h13579BDF);
    bus3.read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pl_en = 1'b1; pl_addr = 8'(i); pl_data = 32'hA0000000 + 32'(i);
      @(negedge clk);
    end
    pl_en = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 50; i++) begin
        buss.read = 1'b1; buss.address = 32'((i % 4) * 4);
        xwait(2, n, d);
        chk($sformatf("jit%0d_%0d_range", p, i), 32'(n >= 1 && n <= 4), 32'd1);
        chk($sformatf("jit%0d_%0d_data", p, i), d, 32'hA0000000 + 32'(i % 4));
        if (p == 0) seq[i] = n;
        else chk($sformatf("jit_repeat_%0d", i), n, seq[i]);
      end
      buss.read = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
    end
    varied = 1'b0;
    for (int i = 1; i < 50; i++) if (seq[i] != seq[0]) varied = 1'b1;
    chk("jit_varied", 32'(varied), 32'd1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
